bcd_display_scanner: RTL and testbench
======================================

# bcd_display_scanner

Time-multiplexed scan controller for a common-anode/common-cathode multi-digit seven-segment display. It holds a packed multi-digit BCD value and steps through the digits at a programmable refresh rate. Each step presents one digit's nibble to the downstream `seven_segment_display` decoder and asserts the matching one-hot digit enable. New values are applied only at frame boundaries, so a digit never shows a mix of old and new values. Leading zeros can be blanked.

## Interface

Parameters:
- `NUM_DIGITS`, 4: number of digits scanned; legal 2..8.
- `REFRESH_DIV`, 50000: clock cycles each digit stays enabled; legal ≥ 2.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous assert and active-low.
- `load`, in, 1: sample `value` on this edge.
- `value`, in, 4*NUM_DIGITS: packed BCD. Nibble k is `value[4k+3:4k]`. Nibble 0 is the least-significant digit.
- `blank_lz`, in, 1: level. When 1, leading zeros are blanked.
- `digit_bcd`, out, 4: nibble for the currently enabled digit. Feeds the decoder's `bin`.
- `digit_sel`, out, NUM_DIGITS: one-hot digit enable, active-high.
- `digit_idx`, out, $clog2(NUM_DIGITS): index of the currently enabled digit.
- `frame_done`, out, 1: one-cycle pulse when the scan wraps back to digit 0.

## Operation

- **Registers**
  - `shadow`: captures `value` on any edge where `load`=1; sets `pending`=1.
  - `active`: the value being displayed.
  - `pending`: new value waiting for the next frame boundary.
- **Refresh tick**
  - `presc` counts 0..REFRESH_DIV-1, then wraps to 0.
  - `tick` is high on the cycle where `presc`==REFRESH_DIV-1.
- **On tick**
  - `digit_idx` advances by 1, wrapping NUM_DIGITS-1 → 0.
  - On the wrap edge: `frame_done` pulses. If `pending`=1, then `active` ← `shadow` and `pending` ← 0.
- **Load collisions**
  - `load` on the wrap edge: the old `shadow` is committed to `active`. The new `value` goes into `shadow` and `pending` stays 1.
  - `load` while `pending`=1: overwrites `shadow`; only the last value before the boundary is shown.
- **Leading-zero blanking**
  - Digit k (k ≥ 1) is blank when `blank_lz`=1 and nibbles k..NUM_DIGITS-1 of `active` are all 0.
  - A blank digit outputs `digit_bcd`=4'hF; the decoder maps codes above 9 to all segments off.
  - Digit 0 is never blanked.
- Non-BCD nibbles (A–F) in `active` pass through unchanged. The decoder shows them as blank.
- **Outputs**
  - `digit_bcd`, `digit_sel`, `digit_idx` and `frame_done` are registered. They are all computed from next-state values, so they change together on the same edge with no glitches.
  - `digit_sel` == (1 << `digit_idx`) at all times.
- **Reset** (asynchronous, while `rst_n`=0):
  - `presc`=0, `digit_idx`=0, `digit_sel`=1.
  - `digit_bcd`=0, `frame_done`=0.
  - `shadow`=0, `active`=0, `pending`=0.
  - Reset in mid-frame discards any pending load.
  - Scan restarts at digit 0 with a full REFRESH_DIV dwell.

## Timing

- Each digit dwells exactly REFRESH_DIV cycles. One frame is NUM_DIGITS×REFRESH_DIV cycles.
- First tick after reset release occurs REFRESH_DIV cycles after the first active edge.
- Load latency: a `load` at edge N appears on `digit_bcd` at the first wrap edge after N. The worst case is one frame.
- `blank_lz` changes take effect at the next tick edge; no frame alignment is required.
- `frame_done` is high for exactly one cycle per frame, on the cycle `digit_idx` becomes 0.

## Structure

- Shared package `display_pkg`:
  - `BLANK_CODE` = 4'hF.
  - A `bcd_digit_t` 4-bit typedef.
  - The default `REFRESH_DIV`.
- Sub-module `refresh_tick_gen`: parameterised by `REFRESH_DIV`; counter plus single-cycle `tick` output; async active-low reset.
- Top level holds `shadow`/`active`/`pending`, the digit index, the blanking logic and the output registers.
- The bench instantiates `seven_segment_display` downstream on `digit_bcd` to check segment patterns end to end.

## Test plan

All scenarios use `NUM_DIGITS`=4 and `REFRESH_DIV`=4.

- **Reset:** hold `rst_n`=0 mid-scan → outputs are immediately `digit_sel`=0001, `digit_bcd`=0, `frame_done`=0. After release, the first advance to `digit_sel`=0010 occurs 4 cycles later.
- **Scan order:** load 16'h1234, `blank_lz`=0 → after the first wrap, `digit_bcd` sequence is 4,3,2,1 with `digit_sel` 0001,0010,0100,1000, 4 cycles each. `frame_done` pulses every 16 cycles.
- **Frame-aligned update:** with 16'h1234 displayed, load 16'h5678 while `digit_idx`=2 → digits 2,3 still show 2,1. The next frame shows 8,7,6,5.
- **Leading-zero blanking:** load 16'h0070 with `blank_lz`=1 → `digit_bcd` per frame is 0,7,F,F, and the decoder segments are 1111110, 1110000, 0000000, 0000000. Load 16'h0000 → the frame is 0,F,F,F.
- **Load collisions:** two loads (16'h1111, then 16'h2222) within one frame → only 2222 is displayed. A load coincident with the wrap edge → the previous shadow is shown this frame and the new value the next frame.
- **Async reset with pending:** reset asserted while `pending`=1 → after release, `active`=0 and digits show 0,0,0,0 with `blank_lz`=0.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared constants and types for the seven-segment scan path
package display_pkg;
  localparam int DEFAULT_REFRESH_DIV = 50000;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BLANK_CODE = 4'hF;
endpackage

// File: rtl/refresh_tick_gen.sv
// refresh_tick_gen: free-running prescaler with a single-cycle tick on its last count
module refresh_tick_gen #(
  parameter int REFRESH_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int PW = $clog2(REFRESH_DIV);
  logic [PW-1:0] presc_q, presc_d;
  always_comb begin
    tick = presc_q == PW'(REFRESH_DIV - 1);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) presc_q <= '0;
    else presc_q <= presc_d;
endmodule

// File: rtl/seven_segment_display.sv
// seven_segment_display: BCD to segments {a,b,c,d,e,f,g}, active-high; codes above 9 are dark
module seven_segment_display (
  input  logic [3:0] bin,
  output logic [6:0] seg
);
  always_comb
    case (bin)
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: frame-aligned multiplexed scan of a packed BCD value with leading-zero blanking
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic                          blank_lz,
  output logic [3:0]                    digit_bcd,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);
  localparam int IW = $clog2(NUM_DIGITS);
  logic tick, wrap, blank;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, active_q, active_d;
  logic pending_q, pending_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  bcd_digit_t bcd_q, bcd_d;
  logic frame_q, frame_d;
  refresh_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );
  // outputs are derived from next-state values so they all move on the same edge
  always_comb begin
    wrap = tick && idx_q == IW'(NUM_DIGITS - 1);
    idx_d = wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
    shadow_d = load ? value : shadow_q;
    active_d = wrap && pending_q ? shadow_q : active_q;
    pending_d = load || (pending_q && !wrap);
    blank = blank_lz && idx_d != '0 && (active_d >> {idx_d, 2'b00}) == '0;
    sel_d = NUM_DIGITS'(1) << idx_d;
    bcd_d = !tick ? bcd_q : blank ? BLANK_CODE : active_d[{idx_d, 2'b00} +: 4];
    frame_d = wrap;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      idx_q     <= '0;
      sel_q     <= NUM_DIGITS'(1);
      bcd_q     <= '0;
      frame_q   <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      bcd_q     <= bcd_d;
      frame_q   <= frame_d;
    end
  assign digit_bcd  = bcd_q;
  assign digit_sel  = sel_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: random and directed scan checks against an edge-count reference model
module tb_bcd_display_scanner;
  localparam int N = 4;
  localparam int R = 4;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, blank_lz = 1'b0, blz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] digit_bcd;
  logic [3:0] digit_sel;
  logic [1:0] digit_idx;
  logic frame_done;
  logic [6:0] seg;
  int checks = 0, errors = 0;
  int e = 0, idx = 0;
  logic [15:0] disp = '0, last_val = '0;
  logic [3:0] exp_bcd = '0;
  logic exp_frame = 1'b0;
  bcd_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank_lz(blank_lz),
    .digit_bcd(digit_bcd), .digit_sel(digit_sel), .digit_idx(digit_idx), .frame_done(frame_done)
  );
  seven_segment_display u_seg (.bin(digit_bcd), .seg(seg));
  always #5 clk = ~clk;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] t [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    return d > 9 ? 7'h00 : t[d];
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask
  task automatic check_outputs();
    check("idx", 32'(digit_idx), 32'(idx));
    check("sel", 32'(digit_sel), 32'(1) << idx);
    check("bcd", 32'(digit_bcd), 32'(exp_bcd));
    check("frame", 32'(frame_done), 32'(exp_frame));
    check("seg", 32'(seg), 32'(seg_of(exp_bcd)));
  endtask
  // model: the display index is edge count / R mod N; each wrap shows the last value loaded strictly before it
  task automatic step(input logic ld, input logic [15:0] v);
    load = ld;
    value = v;
    blank_lz = blz;
    @(posedge clk);
    e++;
    exp_frame = 1'b0;
    if (e % R == 0) begin
      idx = (e / R) % N;
      if (idx == 0) begin
        disp = last_val;
        exp_frame = 1'b1;
      end
      exp_bcd = (blz && idx != 0 && (disp >> (4 * idx)) == 0) ? 4'hF : 4'((disp >> (4 * idx)) & 16'hF);
    end
    if (ld) last_val = v;
    #1;
    load = 1'b0;
    check_outputs();
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask
  task automatic do_reset(input int hold);
    #2 rst_n = 1'b0;
    #1;
    e = 0;
    idx = 0;
    exp_bcd = '0;
    exp_frame = 1'b0;
    disp = '0;
    last_val = '0;
    check_outputs();
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) v[4*k +: 4] = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction
  initial begin
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(6);
    do_reset(2);
    run(5);
    step(1'b1, 16'h1234);
    run(40);
    while (e % 16 != 8) step(1'b0, 16'h0);
    step(1'b1, 16'h5678);
    run(30);
    blz = 1'b1;
    step(1'b1, 16'h0070);
    run(34);
    step(1'b1, 16'h0000);
    run(34);
    blz = 1'b0;
    while (e % 16 != 1) step(1'b0, 16'h0);
    step(1'b1, 16'h1111);
    run(4);
    step(1'b1, 16'h2222);
    run(30);
    while (e % 16 != 15) step(1'b0, 16'h0);
    step(1'b1, 16'h4321);
    run(34);
    step(1'b1, 16'h9999);
    run(3);
    do_reset(1);
    run(36);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) blz = 1'($urandom);
      step($urandom_range(0, 9) == 0, rand_val());
      if (i == 250) do_reset(1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
